// File: rtl/add_round_key_state_if.sv
// Upstream fetch bus: address/select toward the MixColumns memory and key schedule,
// plus the 1-cycle-latency bytes that come back.
interface add_round_key_state_if #(
  parameter int ADDR_W  = 4,
  parameter int KADDR_W = 8
);
  logic               ADD_ROUND_start;
  logic [ADDR_W-1:0]  ADD_ROUND_addr;
  logic [KADDR_W-1:0] key_addr;
  logic [7:0]         data_in;
  logic [7:0]         bypass_in;
  logic [7:0]         key_in;

  modport master (
    output ADD_ROUND_start, ADD_ROUND_addr, key_addr,
    input  data_in, bypass_in, key_in
  );

  modport slave (
    input  ADD_ROUND_start, ADD_ROUND_addr, key_addr,
    output data_in, bypass_in, key_in
  );
endinterface

// File: rtl/add_round_key_state.sv
// Byte-serial AddRoundKey: fetches 16 state bytes and round-key bytes, XORs them
// and keeps the result in a local 16x8 state memory read by the SubBytes stage.
module add_round_key_state #(
  parameter int NBYTES  = 16,
  parameter int KADDR_W = 8,
  parameter int ADDR_W  = $clog2(NBYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           round,
  input  logic                 src_sel,
  add_round_key_state_if.master bus,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [7:0]           out_mem,
  output logic                 busy,
  output logic                 DONE
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBYTES - 1);

  state_t            state;
  logic [3:0]        round_q;
  logic              src_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        mem [NBYTES];
  logic [7:0]        result;

  assign result = (src_q ? bus.bypass_in : bus.data_in) ^ bus.key_in;

  always_ff @(posedge clk) begin : fsm
    if (rst) begin
      state               <= IDLE;
      round_q             <= '0;
      src_q               <= 1'b0;
      bus.ADD_ROUND_start <= 1'b0;
      bus.ADD_ROUND_addr  <= '0;
      bus.key_addr        <= '0;
      busy                <= 1'b0;
      DONE                <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            round_q             <= round;
            src_q               <= src_sel;
            state               <= FETCH;
            bus.ADD_ROUND_start <= 1'b1;
            bus.ADD_ROUND_addr  <= '0;
            bus.key_addr        <= KADDR_W'({round, 4'b0000});
            busy                <= 1'b1;
          end
        end
        FETCH: begin
          // Address holds at the last byte through DRAIN; it only returns to 0 in IDLE.
          if (bus.ADD_ROUND_addr == LAST) begin
            state <= DRAIN;
          end else begin
            bus.ADD_ROUND_addr <= bus.ADD_ROUND_addr + 1'b1;
            bus.key_addr       <= KADDR_W'({round_q, 4'b0000})
                                  + KADDR_W'(bus.ADD_ROUND_addr) + KADDR_W'(1);
          end
        end
        DRAIN: begin
          state               <= FIN;
          bus.ADD_ROUND_start <= 1'b0;
          busy                <= 1'b0;
          DONE                <= 1'b1;
        end
        FIN: begin
          state              <= IDLE;
          DONE               <= 1'b0;
          bus.ADD_ROUND_addr <= '0;
          bus.key_addr       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write lags the fetch address by one cycle to match the source memories' read latency.
  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      out_mem <= '0;
      for (int i = 0; i < NBYTES; i++) mem[i] <= '0;
    end else begin
      wr_en   <= (state == FETCH);
      wr_addr <= bus.ADD_ROUND_addr;
      if (wr_en) mem[wr_addr] <= result;
      out_mem <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_add_round_key_state.sv
// Bench for add_round_key_state: source memory models, FIPS-197 vectors and
// randomized rounds checked against a byte-level XOR reference model.
module tb_add_round_key_state;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] round;
  logic       src_sel;
  logic [3:0] rd_addr;
  logic [7:0] out_mem;
  logic       busy;
  logic       done;

  add_round_key_state_if bus ();

  add_round_key_state dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .round   (round),
    .src_sel (src_sel),
    .bus     (bus),
    .rd_addr (rd_addr),
    .out_mem (out_mem),
    .busy    (busy),
    .DONE    (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mc_mem    [16];
  logic [7:0] bp_mem    [16];
  logic [7:0] key_mem   [256];
  logic [7:0] model_mem [16];
  logic [7:0] lit_mem   [16];
  int checks = 0;
  int errors = 0;

  // Registered-read source memories, one cycle behind the addresses the DUT drives.
  always @(posedge clk) begin
    bus.data_in   <= mc_mem[bus.ADD_ROUND_addr];
    bus.bypass_in <= bp_mem[bus.ADD_ROUND_addr];
    bus.key_in    <= key_mem[bus.key_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic readMem(input int nlit);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      checkOutput($sformatf("mem[%0d]", a), 32'(out_mem), 32'(model_mem[a]));
      if (a < nlit) checkOutput($sformatf("lit[%0d]", a), 32'(out_mem), 32'(lit_mem[a]));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic s, input int restart_cycle,
                               input int reset_cycle, input bit rd_probe);
    logic [7:0] exp_mem [16];
    logic [7:0] old5;
    for (int i = 0; i < 16; i++)
      exp_mem[i] = (s ? bp_mem[i] : mc_mem[i]) ^ key_mem[(int'(r) * 16 + i) % 256];
    old5 = model_mem[5];
    if (rd_probe) rd_addr = 4'd5;
    @(negedge clk);
    start = 1'b1; round = r; src_sel = s;
    @(negedge clk);
    start = 1'b0; round = 4'($urandom); src_sel = 1'($urandom);
    for (int k = 0; k <= 18; k++) begin
      checkOutput($sformatf("ars c%0d", k), 32'(bus.ADD_ROUND_start), 32'(k <= 16));
      checkOutput($sformatf("busy c%0d", k), 32'(busy), 32'(k <= 16));
      checkOutput($sformatf("done c%0d", k), 32'(done), 32'(k == 17));
      if (k <= 15) begin
        checkOutput($sformatf("key_addr c%0d", k), 32'(bus.key_addr), (int'(r) * 16 + k) % 256);
        checkOutput($sformatf("addr c%0d", k), 32'(bus.ADD_ROUND_addr), k);
      end
      if (k == 16) checkOutput("addr hold", 32'(bus.ADD_ROUND_addr), 15);
      if (k == 18) checkOutput("addr idle", 32'(bus.ADD_ROUND_addr), 0);
      if (rd_probe && k == 7) checkOutput("rd old", 32'(out_mem), 32'(old5));
      if (rd_probe && k == 8) checkOutput("rd new", 32'(out_mem), 32'(exp_mem[5]));
      if (k == reset_cycle) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst busy", 32'(busy), 0);
        checkOutput("rst ars", 32'(bus.ADD_ROUND_start), 0);
        checkOutput("rst done", 32'(done), 0);
        checkOutput("rst addr", 32'(bus.ADD_ROUND_addr), 0);
        checkOutput("rst key_addr", 32'(bus.key_addr), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        return;
      end
      if (k == restart_cycle) begin
        start = 1'b1; round = 4'd7; src_sel = ~s;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = exp_mem[i];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; round = '0; src_sel = 1'b0; rd_addr = '0;
    for (int i = 0; i < 256; i++) key_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      mc_mem[i] = 8'($urandom); bp_mem[i] = 8'($urandom); model_mem[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset ars", 32'(bus.ADD_ROUND_start), 0);
    checkOutput("reset addr", 32'(bus.ADD_ROUND_addr), 0);
    checkOutput("reset key_addr", 32'(bus.key_addr), 0);
    checkOutput("reset out_mem", 32'(out_mem), 0);
    rst = 1'b0;
    readMem(0);

    // FIPS-197 round 0: plaintext bypass XOR cipher key
    bp_mem  = '{8'h32, 8'h43, 8'hf6, 8'ha8, 8'h88, 8'h5a, 8'h30, 8'h8d,
                8'h31, 8'h31, 8'h98, 8'ha2, 8'he0, 8'h37, 8'h07, 8'h34};
    lit_mem = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    key_mem[0:15] = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
                      8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
    applyStimulus(4'd0, 1'b1, -1, -1, 1'b0);
    readMem(16);

    // Round 1 from MixColumns data, with the same-address read probe
    mc_mem[0] = 8'h04; mc_mem[1] = 8'h66; mc_mem[2] = 8'h81; mc_mem[3] = 8'he5;
    key_mem[16] = 8'ha0; key_mem[17] = 8'hfa; key_mem[18] = 8'hfe; key_mem[19] = 8'h17;
    lit_mem[0] = 8'ha4; lit_mem[1] = 8'h9c; lit_mem[2] = 8'h7f; lit_mem[3] = 8'hf2;
    applyStimulus(4'd1, 1'b0, -1, -1, 1'b1);
    readMem(4);

    // Final round: ShiftRows bytes XOR round key 10 give the FIPS-197 ciphertext
    bp_mem  = '{8'he9, 8'h31, 8'h7d, 8'hb5, 8'hcb, 8'h32, 8'h2c, 8'h72,
                8'h3d, 8'h2e, 8'h89, 8'h5f, 8'haf, 8'h09, 8'h07, 8'h94};
    key_mem[160:175] = '{8'hd0, 8'h14, 8'hf9, 8'ha8, 8'hc9, 8'hee, 8'h25, 8'h89,
                         8'he1, 8'h3f, 8'h0c, 8'hc8, 8'hb6, 8'h63, 8'h0c, 8'ha6};
    lit_mem = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
                8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};
    applyStimulus(4'd10, 1'b1, -1, -1, 1'b0);
    readMem(16);

    // Start pulsed while busy must not disturb the running operation
    for (int i = 0; i < 16; i++) mc_mem[i] = 8'($urandom);
    applyStimulus(4'd3, 1'b0, 5, -1, 1'b0);
    readMem(0);

    // Reset mid-operation clears everything, then a fresh run completes
    applyStimulus(4'd4, 1'b0, -1, 8, 1'b0);
    readMem(0);
    applyStimulus(4'd2, 1'b1, -1, -1, 1'b0);
    readMem(0);

    // start together with rst: reset wins
    @(negedge clk);
    start = 1'b1; rst = 1'b1; round = 4'd5;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    checkOutput("rst+start busy", 32'(busy), 0);
    @(negedge clk);
    checkOutput("rst+start idle", 32'(bus.ADD_ROUND_start), 0);
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    readMem(0);

    // Randomized rounds, including out-of-range 11..15 key addresses
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) begin
        mc_mem[i] = 8'($urandom); bp_mem[i] = 8'($urandom);
      end
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom), -1, -1, 1'b0);
      readMem(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
